sync_down_counter: RTL and testbench
====================================

# sync_down_counter

Fully synchronous, loadable, parameterized down counter that counts toward zero and produces a registered borrow pulse at expiry. It complements the team's ripple up counters for timing and delay generation: the same 3-bit default width, but a single clock domain, a programmable reload value, and a one-shot mode. Typical uses are programmable delays, timeouts and clock-enable dividers.

## Interface
- WIDTH, 3: counter width in bits (≥1).
- clk  input  1  single clock. All state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable, sampled on the rising clk edge.
- load  input  1  synchronous load strobe. Has priority over en.
- load_val  input  WIDTH  start/reload value, captured when load=1.
- mode  input  1  0 = auto-reload (periodic), 1 = one-shot.
- Q  output  WIDTH  current count, registered.
- tc  output  1  terminal count: combinational (Q == 0).
- borrow  output  1  registered one-cycle pulse at expiry.
- busy  output  1  high while the FSM is in RUN.

## Operation
- Internal state:
  - reload_reg (WIDTH bits).
  - FSM with states RUN and DONE, 1-bit encoding.
- Reset (async, immediate) sets:
  - Q = all ones (7 for WIDTH=3)
  - reload_reg = all ones
  - state = RUN
  - borrow = 0
  - As a result, tc = 0 and busy = 1.
- Rules are evaluated each rising edge, in priority order:
  1. **load=1**: Q ← load_val, reload_reg ← load_val, state ← RUN, borrow ← 0. Valid in any state.
  2. **RUN, en=1, Q≠0**: Q ← Q−1, borrow ← 0.
  3. **RUN, en=1, Q=0, mode=0**: Q ← reload_reg, borrow ← 1, state stays RUN.
  4. **RUN, en=1, Q=0, mode=1**: Q stays 0, borrow ← 1, state ← DONE.
  5. **Otherwise**: Q and state hold, borrow ← 0.
- DONE:
  - en is ignored and Q holds 0.
  - The only exits are load or rst.
- Auto-reload period is reload_reg+1 enabled cycles, so borrow occurs once per reload_reg+1 enables.
- load_val = 0:
  - mode 0: Q stays 0 and borrow pulses on every enabled cycle.
  - mode 1: the first enabled cycle gives borrow and DONE.
- Arithmetic is modulo 2^WIDTH. Underflow cannot occur because Q=0 always takes reload or stop, never decrement.
- mode is sampled only at the Q=0 enabled edge. A mode change mid-count takes effect at the next expiry.
- Simultaneous load and en: load wins, no decrement, no borrow.

## Timing
- Latency:
  - Q changes one edge after en/load sampling.
  - borrow asserts in the same cycle the reloaded or held Q appears, for exactly one clk period per expiry.
  - tc follows Q combinationally, with zero cycles after the Q update.
- en deasserted: Q, state and reload_reg hold indefinitely, and borrow drops to 0 at the next edge.
- rst asserted mid-count forces the reset values asynchronously, without waiting for clk. After rst falls, the first active edge obeys the normal rules.
- No combinational path from any input to any output except Q→tc.

## Test plan
- **Reset**: assert rst between edges → Q=7, tc=0, borrow=0, busy=1 immediately. Release rst, hold en=1, mode=0 → Q sequence 6,5,4,3,2,1,0,7,6…; borrow=1 only in the cycle Q returns to 7.
- **Auto-reload**: load_val=4 with load=1, then mode=0, en=1 for 12 cycles → Q sequence 4,3,2,1,0,4,3,2,1,0,4…; borrow period is 5 cycles; tc=1 exactly when Q=0.
- **One-shot**: load_val=2, mode=1, en=1 → Q sequence 2,1,0, then borrow=1 for one cycle, busy=0 and Q stuck at 0. Further en pulses cause no borrow. A later load of 3 restores busy=1 and Q=3.
- **Priority and gating**: at Q=5, drive load=1, en=1, load_val=6 → Q=6 with no decrement. Pulse en every other cycle → Q decrements only on enabled edges; borrow width stays 1 cycle.
- **Edge values**: load_val=0 in mode 0 → Q=0, tc=1 and borrow=1 on every enabled cycle. load_val=0 in mode 1 → one borrow, then DONE.
- **Async reset mid-operation**: in DONE, or at Q=3 with borrow pending, assert rst → all outputs reach their reset values before the next edge. Then verify WIDTH=5 instantiation: reset Q=31 and wrap 0→reload.

Source files
------------

// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down counter with auto-reload/one-shot modes and a registered borrow pulse
module sync_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             borrow,
  output logic             busy
);
  typedef enum logic {RUN, DONE} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, reload_q, reload_d;
  logic             borrow_q, borrow_d;
  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    state_d  = state_q;
    borrow_d = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      state_d  = RUN;
    end else if (state_q == RUN && en) begin
      if (q_q != '0) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        borrow_d = 1'b1;
        q_d      = mode ? q_q : reload_q;
        state_d  = mode ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= '1;
      reload_q <= '1;
      state_q  <= RUN;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      borrow_q <= borrow_d;
    end
  end
  assign Q      = q_q;
  assign tc     = (q_q == '0);
  assign borrow = borrow_q;
  assign busy   = (state_q == RUN);
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: vector table plus directed async-reset and WIDTH=5 sequences
module tb_sync_down_counter;
  logic       clk = 1'b0;
  logic       rst, en, load, mode;
  logic [2:0] load_val, q;
  logic       tc, borrow, busy;
  logic       rst5, en5, load5, mode5;
  logic [4:0] load_val5, q5;
  logic       tc5, borrow5, busy5;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ld, en, mode;
    logic [2:0] lv, q;
    logic       b, busy;
  } vec_t;
  vec_t vecs[$];

  sync_down_counter #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .mode(mode),
    .Q(q), .tc(tc), .borrow(borrow), .busy(busy)
  );
  sync_down_counter #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst5), .en(en5), .load(load5), .load_val(load_val5), .mode(mode5),
    .Q(q5), .tc(tc5), .borrow(borrow5), .busy(busy5)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ld, input logic e, input logic m, input logic [2:0] lv,
                     input logic [2:0] eq, input logic eb, input logic ebusy);
    vec_t v;
    v.ld = ld; v.en = e; v.mode = m; v.lv = lv; v.q = eq; v.b = eb; v.busy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string tag, input logic [2:0] eq, input logic eb, input logic ebusy);
    check({tag, " Q"}, 32'(q), 32'(eq));
    check({tag, " tc"}, 32'(tc), 32'(eq == 3'd0));
    check({tag, " borrow"}, 32'(borrow), 32'(eb));
    check({tag, " busy"}, 32'(busy), 32'(ebusy));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0; load_val = 3'd0;
    rst5 = 1'b1; en5 = 1'b0; load5 = 1'b0; mode5 = 1'b0; load_val5 = 5'd0;
    // reset release count: 7 -> 6..0 -> 7 with borrow
    for (int i = 6; i >= 0; i--) add(0, 1, 0, 0, 3'(i), 0, 1);
    add(0, 1, 0, 0, 7, 1, 1);
    add(0, 1, 0, 0, 6, 0, 1);
    // auto-reload of 4, load wins over en
    add(1, 1, 0, 4, 4, 0, 1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 3; i >= 0; i--) add(0, 1, 0, 0, 3'(i), 0, 1);
      add(0, 1, 0, 0, 4, 1, 1);
    end
    add(0, 0, 0, 0, 4, 0, 1);
    // one-shot from 2
    add(1, 0, 1, 2, 2, 0, 1);
    add(0, 1, 1, 0, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 3, 3, 0, 1);
    // priority at Q=5, then en every other cycle
    add(1, 0, 0, 5, 5, 0, 1);
    add(1, 1, 0, 6, 6, 0, 1);
    for (int i = 5; i >= 0; i--) begin
      add(0, 1, 0, 0, 3'(i), 0, 1);
      add(0, 0, 0, 0, 3'(i), 0, 1);
    end
    add(0, 1, 0, 0, 6, 1, 1);
    add(0, 0, 0, 0, 6, 0, 1);
    // load_val = 0 in both modes
    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0);

    #2 rst = 1'b1;
    #1 check_all("reset", 7, 0, 1);
    #1 rst = 1'b0;
    foreach (vecs[i]) begin
      load = vecs[i].ld; en = vecs[i].en; mode = vecs[i].mode; load_val = vecs[i].lv;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].busy);
    end

    // async reset while in DONE
    load = 1'b0; en = 1'b0;
    #1 rst = 1'b1;
    #1 check_all("rst_done", 7, 0, 1);
    rst = 1'b0;
    // reach Q=3 with borrow asserted, then async reset
    load = 1'b1; load_val = 3'd3; mode = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_all("reload3", 3, 1, 1);
    #1 rst = 1'b1;
    #1 check_all("rst_borrow", 7, 0, 1);
    rst = 1'b0; en = 1'b0;

    // WIDTH=5: reset to 31, count down and wrap back to 31
    #1 check("w5 reset Q", 32'(q5), 32'd31);
    check("w5 reset tc", 32'(tc5), 32'd0);
    rst5 = 1'b0; en5 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      check($sformatf("w5 Q%0d", i), 32'(q5), (i < 31) ? 32'(30 - i) : 32'd31);
      check($sformatf("w5 b%0d", i), 32'(borrow5), (i == 31) ? 32'd1 : 32'd0);
    end
    load5 = 1'b1; load_val5 = 5'd2;
    step();
    load5 = 1'b0;
    step(); step();
    check("w5 tc at 0", 32'(tc5), 32'd1);
    step();
    check("w5 reload Q", 32'(q5), 32'd2);
    check("w5 reload b", 32'(borrow5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
